// File: rtl/icache_plru.sv
// Tree pseudo-LRU replacement state for the 8-way, 64-set icache.
// Takes hit and refill access updates and answers victim-way queries.
//
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   hit_read2plru_*       - access update from the hit-read stage
//   refill2plru_*         - access update from the refill path
//   ctrl2plru_*           - victim query from the icache controller
//   plru2ctrl_*           - registered victim result (one-cycle pulse)
//
// Tree bits per set, packed as tree[6:0] = {b6..b0}:
//   b0 root (0 = ways 0-3), b1 ways 0-3, b2 ways 4-7,
//   b3 ways 0/1, b4 ways 2/3, b5 ways 4/5, b6 ways 6/7.
module icache_plru #(
   parameter int INDEX_W = 6,
   parameter int WAY_W   = 3
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               hit_read2plru_valid,
   input  logic [INDEX_W-1:0] hit_read2plru_index,
   input  logic [WAY_W-1:0]   hit_read2plru_way,
   input  logic               refill2plru_valid,
   input  logic [INDEX_W-1:0] refill2plru_index,
   input  logic [WAY_W-1:0]   refill2plru_way,
   input  logic               ctrl2plru_valid,
   input  logic [INDEX_W-1:0] ctrl2plru_index,
   output logic               plru2ctrl_valid,
   output logic [WAY_W-1:0]   plru2ctrl_way
);

   localparam int SETS   = 1 << INDEX_W;
   localparam int TREE_W = (1 << WAY_W) - 1;

   typedef logic [TREE_W-1:0] tree_t;

   tree_t             tree_q [SETS];
   tree_t             tree_d [SETS];
   logic              valid_q;
   logic              valid_d;
   logic [WAY_W-1:0]  way_q;
   logic [WAY_W-1:0]  way_d;

   // Point every node on way w's path away from w.
   function automatic tree_t touch(input tree_t t,
                                   input logic [WAY_W-1:0] w);
      tree_t r;
      r    = t;
      r[0] = ~w[2];
      unique case (1'b1)
         (w[2:1] == 2'b00): begin
            r[1] = 1'b1;
            r[3] = ~w[0];
         end
         (w[2:1] == 2'b01): begin
            r[1] = 1'b0;
            r[4] = ~w[0];
         end
         (w[2:1] == 2'b10): begin
            r[2] = 1'b1;
            r[5] = ~w[0];
         end
         default: begin
            r[2] = 1'b0;
            r[6] = ~w[0];
         end
      endcase
      return r;
   endfunction

   // Follow the pointers from the root down to a leaf.
   function automatic logic [WAY_W-1:0] walk(input tree_t t);
      logic [WAY_W-1:0] w;
      w = '0;
      unique case (1'b1)
         (t[0] == 1'b0): begin
            w[2] = 1'b0;
            w[1] = t[1];
            w[0] = t[1] ? t[4] : t[3];
         end
         default: begin
            w[2] = 1'b1;
            w[1] = t[2];
            w[0] = t[2] ? t[6] : t[5];
         end
      endcase
      return w;
   endfunction

   // Hit is applied first and refill second, so on a shared set
   // the refill path wins any bit both paths touch.
   always_comb begin
      tree_d = tree_q;
      if (hit_read2plru_valid) begin
         tree_d[hit_read2plru_index] =
            touch(tree_d[hit_read2plru_index], hit_read2plru_way);
      end
      if (refill2plru_valid) begin
         tree_d[refill2plru_index] =
            touch(tree_d[refill2plru_index], refill2plru_way);
      end
   end

   // Query reads pre-update state; same-cycle updates are not bypassed.
   always_comb begin
      valid_d = ctrl2plru_valid;
      way_d   = way_q;
      if (ctrl2plru_valid) begin
         way_d = walk(tree_q[ctrl2plru_index]);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SETS; i++) begin
            tree_q[i] <= '0;
         end
         valid_q <= 1'b0;
         way_q   <= '0;
      end else begin
         for (int i = 0; i < SETS; i++) begin
            tree_q[i] <= tree_d[i];
         end
         valid_q <= valid_d;
         way_q   <= way_d;
      end
   end

   assign plru2ctrl_valid = valid_q;
   assign plru2ctrl_way   = way_q;

endmodule

// File: tb/tb_icache_plru.sv
// Self-checking bench for icache_plru: heap-indexed tree model
// compared every cycle, plus literal expectations on directed cases.
module tb_icache_plru;

   logic       clock = 1'b0;
   logic       reset;
   logic       hit_v;
   logic [5:0] hit_idx;
   logic [2:0] hit_way;
   logic       ref_v;
   logic [5:0] ref_idx;
   logic [2:0] ref_way;
   logic       q_v;
   logic [5:0] q_idx;
   logic       r_v;
   logic [2:0] r_way;

   int tests = 0;
   int fails = 0;

   icache_plru #(.INDEX_W(6), .WAY_W(3)) dut (
      .clock               (clock),
      .reset               (reset),
      .hit_read2plru_valid (hit_v),
      .hit_read2plru_index (hit_idx),
      .hit_read2plru_way   (hit_way),
      .refill2plru_valid   (ref_v),
      .refill2plru_index   (ref_idx),
      .refill2plru_way     (ref_way),
      .ctrl2plru_valid     (q_v),
      .ctrl2plru_index     (q_idx),
      .plru2ctrl_valid     (r_v),
      .plru2ctrl_way       (r_way)
   );

   always #5 clock = ~clock;

   // Model: node n (1..7) of a binary heap; node n's children are
   // 2n and 2n+1, bit value picks the child the victim lies under.
   bit       node [64][8];
   bit       exp_v;
   bit [2:0] exp_way;
   bit       started = 0;

   function automatic bit [2:0] m_victim(input int s);
      int n;
      bit [2:0] w;
      n = 1;
      w = 0;
      for (int l = 0; l < 3; l++) begin
         w = {w[1:0], node[s][n]};
         n = 2 * n + int'(node[s][n]);
      end
      return w;
   endfunction

   task automatic m_touch(input int s, input bit [2:0] w);
      int n;
      n = 1;
      for (int l = 2; l >= 0; l--) begin
         node[s][n] = ~w[l];
         n = 2 * n + int'(w[l]);
      end
   endtask

   always @(posedge clock) begin
      if (reset) begin
         foreach (node[s, n]) node[s][n] = 0;
         exp_v   = 0;
         exp_way = 0;
         started = 1;
      end else begin
         exp_v = q_v;
         if (q_v) exp_way = m_victim(int'(q_idx));
         if (hit_v) m_touch(int'(hit_idx), hit_way);
         if (ref_v) m_touch(int'(ref_idx), ref_way);
      end
   end

   always @(negedge clock) begin
      if (started) begin
         tests++;
         if (r_v !== exp_v || r_way !== exp_way) begin
            fails++;
            $display("FAIL model t=%0t got v=%b way=%0d want v=%b way=%0d",
                     $time, r_v, r_way, exp_v, exp_way);
         end
      end
   end

   task automatic lit(input string nm, input bit v, input bit [2:0] w);
      tests++;
      if (r_v !== v || r_way !== w) begin
         fails++;
         $display("FAIL %s got v=%b way=%0d want v=%b way=%0d",
                  nm, r_v, r_way, v, w);
      end
   endtask

   task automatic idle();
      reset = 0;
      hit_v = 0; hit_idx = 0; hit_way = 0;
      ref_v = 0; ref_idx = 0; ref_way = 0;
      q_v   = 0; q_idx   = 0;
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic query(input int s);
      q_v = 1; q_idx = 6'(s);
   endtask

   task automatic hit(input int s, input int w);
      hit_v = 1; hit_idx = 6'(s); hit_way = 3'(w);
   endtask

   task automatic refill(input int s, input int w);
      ref_v = 1; ref_idx = 6'(s); ref_way = 3'(w);
   endtask

   initial begin
      idle();
      reset = 1;
      tick(); tick();
      idle();
      lit("reset_state", 0, 0);
      query(0);
      tick(); lit("q0_after_reset", 1, 0);
      idle();
      tick(); lit("pulse_ends", 0, 0);

      hit(5, 0);
      tick(); idle(); query(5);
      tick(); lit("set5_after_w0", 1, 4);
      idle(); query(6);
      tick(); lit("set6_untouched", 1, 0);
      idle();

      for (int w = 0; w < 8; w++) begin
         tick(); idle(); hit(2, w);
      end
      tick(); idle(); query(2);
      tick(); lit("set2_sweep", 1, 0);
      idle();

      hit(3, 0); refill(3, 4);
      tick(); idle(); query(3);
      tick(); lit("refill_wins", 1, 2);
      idle(); tick(); lit("way_holds", 0, 2);

      query(9); hit(9, 0);
      tick(); lit("no_bypass", 1, 0);
      idle(); query(9);
      tick(); lit("set9_updated", 1, 4);
      idle();

      hit(10, 7); refill(11, 2);
      tick(); idle(); query(10);
      tick(); lit("dual_set10", 1, 0);
      idle(); query(11);
      tick(); lit("dual_set11", 1, 4);
      idle();

      hit(7, 5); refill(7, 5);
      tick(); idle(); query(7);
      tick(); lit("same_way", 1, 0);
      idle();

      hit(1, 0);
      tick(); idle(); reset = 1; query(1);
      tick(); idle();
      lit("reset_kills_q", 0, 0);
      query(1);
      tick(); lit("set1_cleared", 1, 0);
      idle();

      for (int c = 0; c < 400; c++) begin
         tick(); idle();
         if ($urandom_range(0, 1) == 1)
            hit($urandom_range(0, 3), $urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0)
            refill($urandom_range(0, 3), $urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1)
            query($urandom_range(0, 3));
      end
      tick(); idle();
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
